// File: rtl/udp_pkt_filter.sv
// Byte-stream Ethernet/IPv4/UDP header filter: forwards only the UDP payload of matching frames.
// Optional per-frame accept/drop counters when UDP_FILTER_STATS_EN is defined.
module udp_pkt_filter #(
  parameter int          CNT_W    = 6,
  parameter logic [15:0] ETH_TYPE = 16'h0800,
  parameter logic [7:0]  IP_PROTO = 8'h11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] udp_port_to_match,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data
`ifdef UDP_FILTER_STATS_EN
  ,
  output logic [15:0] pkt_accept_cnt,
  output logic [15:0] pkt_drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(41);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             hdr_fail;
  logic             hdr_pass;
  logic             frame_drop;

  // cnt is the offset of the byte currently on in_data; zero while idle.
  always_comb begin
    hdr_fail = 1'b0;
    case (cnt)
      CNT_W'(12): hdr_fail = (in_data != ETH_TYPE[15:8]);
      CNT_W'(13): hdr_fail = (in_data != ETH_TYPE[7:0]);
      CNT_W'(14): hdr_fail = (in_data != 8'h45);
      CNT_W'(20): hdr_fail = (in_data[5:0] != 6'd0);   // MF and frag offset high bits; DF ignored
      CNT_W'(21): hdr_fail = (in_data != 8'h00);
      CNT_W'(23): hdr_fail = (in_data != IP_PROTO);
      CNT_W'(36): hdr_fail = (in_data != udp_port_to_match[15:8]);
      CNT_W'(37): hdr_fail = (in_data != udp_port_to_match[7:0]);
      default:    hdr_fail = 1'b0;
    endcase
  end

  assign hdr_pass   = (state == HEADER) && in_valid && !hdr_fail && (cnt == LAST_HDR);
  assign frame_drop = !in_valid && ((state == HEADER) || (state == DROP));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = HEADER;
      HEADER: begin
        if (!in_valid)     state_nxt = IDLE;
        else if (hdr_fail) state_nxt = DROP;
        else if (hdr_pass) state_nxt = PAYLOAD;
      end
      PAYLOAD: if (!in_valid) state_nxt = IDLE;
      DROP:    if (!in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (!in_valid)           cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      out_valid <= (state == PAYLOAD) && in_valid;
      if ((state == PAYLOAD) && in_valid) out_data <= in_data;
    end
  end

`ifdef UDP_FILTER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_accept_cnt <= '0;
      pkt_drop_cnt   <= '0;
    end else begin
      if (hdr_pass)   pkt_accept_cnt <= pkt_accept_cnt + 16'd1;
      if (frame_drop) pkt_drop_cnt   <= pkt_drop_cnt + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_drop;
`endif

endmodule

// File: tb/tb_udp_pkt_filter.sv
// Scoreboard bench for udp_pkt_filter: driver queues expected payload bytes with their
// expected output cycle, a negedge monitor pops and compares whenever out_valid is high.
module tb_udp_pkt_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] udp_port_to_match;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [7:0]  out_data;
`ifdef UDP_FILTER_STATS_EN
  logic [15:0] pkt_accept_cnt, pkt_drop_cnt;
`endif

  udp_pkt_filter dut (
    .clk(clk), .reset(reset), .udp_port_to_match(udp_port_to_match),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
`ifdef UDP_FILTER_STATS_EN
    , .pkt_accept_cnt(pkt_accept_cnt), .pkt_drop_cnt(pkt_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; int c;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] frm[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int exp_acc = 0, exp_drp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid cycle must match the oldest expected byte and its cycle.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got data=%02h at cycle %0d, expected no output", out_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.d || cyc != e.c) begin
          n_err++;
          $display("FAIL payload_byte: got %02h@%0d, expected %02h@%0d", out_data, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic mk(input logic [15:0] et, input logic [7:0] b14, input logic [7:0] b20,
                    input logic [7:0] b21, input logic [7:0] proto, input logic [15:0] dport);
    frm.delete();
    for (int i = 0; i < 42; i++) frm.push_back(8'(i * 7 + 1));
    frm[12] = et[15:8];  frm[13] = et[7:0];
    frm[14] = b14;       frm[20] = b20;    frm[21] = b21;
    frm[23] = proto;     frm[36] = dport[15:8]; frm[37] = dport[7:0];
  endtask

  task automatic add_std_payload();
    logic [7:0] pl [8];
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFE, 8'hED, 8'hCA, 8'hFE};
    for (int i = 0; i < 8; i++) frm.push_back(pl[i]);
  endtask

  // Sends frm, then gap idle cycles. pass selects whether payload is expected out.
  task automatic send(input bit pass, input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[i];
      if (pass && i >= 42) exp_q.push_back('{frm[i], cyc + 1});
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h5A;
    end
    if (pass) exp_acc++; else exp_drp++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; udp_port_to_match = 16'd1234;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic pass frame
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(1, 2);
    // Each single-field failure must drop
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D3); add_std_payload(); send(0, 2);
    mk(16'h0806, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(0, 2);
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h01, 16'h04D2); add_std_payload(); send(0, 2);
    mk(16'h0800, 8'h46, 8'h00, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(0, 2);
    mk(16'h0800, 8'h45, 8'h20, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(0, 2);
    mk(16'h0800, 8'h45, 8'h00, 8'h01, 8'h11, 16'h04D2); add_std_payload(); send(0, 1);
    // DF set is ignored
    mk(16'h0800, 8'h45, 8'h40, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(1, 1);

    // Runt, then a good frame on the very next valid cycle after one idle
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2);
    frm = frm[0:17];
    send(0, 1);
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(1, 1);

    // 63-byte frame, payload 00..14
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2);
    for (int i = 0; i < 21; i++) frm.push_back(8'(i));
    send(1, 2);
    // 42-byte frame: passes header, no payload
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2); send(1, 2);
    // 90-byte frame: forwarding continues past counter saturation
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2);
    for (int i = 0; i < 48; i++) frm.push_back(8'(8'h80 + i));
    send(1, 2);

    // Pass, 5 idle, port mismatch
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2); add_std_payload(); send(1, 5);
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h1234); add_std_payload(); send(0, 3);

`ifdef UDP_FILTER_STATS_EN
    check("accept_cnt", 32'(pkt_accept_cnt), 32'(exp_acc));
    check("drop_cnt", 32'(pkt_drop_cnt), 32'(exp_drp));
`endif

    // Reset mid-frame after 20 bytes, held 2 cycles
    mk(16'h0800, 8'h45, 8'h00, 8'h00, 8'h11, 16'h04D2); add_std_payload();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = frm[i];
    end
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); check("mid_reset_out_valid_0", 32'(out_valid), 32'd0);
    @(negedge clk); check("mid_reset_out_valid_1", 32'(out_valid), 32'd0);
    reset = 1'b0; exp_acc = 0; exp_drp = 0;
    @(negedge clk);
    send(1, 3);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef UDP_FILTER_STATS_EN
    check("accept_cnt_post_reset", 32'(pkt_accept_cnt), 32'(exp_acc));
    check("drop_cnt_post_reset", 32'(pkt_drop_cnt), 32'(exp_drp));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
